// File: rtl/pixel_coord_tracker.sv
// pixel_coord_tracker
//   Converts a row-major pixel_index stream into raster x/y, grid cell
//   column/row and the pixel's offset inside its cell, without dividers.
//   A raster-order index (prev+1, or the wrap from the last pixel to 0)
//   is resolved in one cycle by stepping counters. Any other index is
//   resolved by a repeated-subtraction resync: rows first, then cells.
//
// Handshake: a request is accepted on a rising clk edge when pix_valid=1
//   and busy=0. Each accepted request produces exactly one out_valid pulse.
//   Requests presented while busy=1 are dropped with no response.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   pix_valid      request strobe
//   pixel_index    linear row-major index
//   flip_x/flip_y  mirror x/y on the output; sampled at accept
//   busy           resync in progress
//   out_valid      one-cycle result pulse
//   x, y           mirrored raster coordinates
//   cell_col/row   unmirrored grid cell coordinates
//   cell_x/cell_y  unmirrored offset inside the cell
//   out_of_range   last accepted index was >= WIDTH*HEIGHT
//   fsm_state      debug view of the control FSM (0 TRACK, 1 RS_ROW, 2 RS_COL)
module pixel_coord_tracker #(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64,
  parameter int IDX_W  = 13,
  parameter int X_W    = 7,
  parameter int Y_W    = 6,
  parameter int CELL_W = 8,
  parameter int CELL_H = 8,
  parameter int CX_W   = 4,
  parameter int CY_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic [IDX_W-1:0] pixel_index,
  input  logic             flip_x,
  input  logic             flip_y,
  output logic             busy,
  output logic             out_valid,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [CX_W-1:0]  cell_col,
  output logic [CY_W-1:0]  cell_row,
  output logic [CX_W-1:0]  cell_x,
  output logic [CY_W-1:0]  cell_y,
  output logic             out_of_range,
  output logic [1:0]       fsm_state
);

  localparam logic [X_W-1:0]   X_MAX   = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_MAX   = Y_W'(HEIGHT - 1);
  localparam logic [CX_W-1:0]  CX_LAST = CX_W'(CELL_W - 1);
  localparam logic [CY_W-1:0]  CY_LAST = CY_W'(CELL_H - 1);
  localparam logic [IDX_W:0]   TOTAL   = (IDX_W+1)'(WIDTH * HEIGHT);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(WIDTH * HEIGHT - 1);
  localparam logic [IDX_W-1:0] W_IDX   = IDX_W'(WIDTH);
  localparam logic [IDX_W-1:0] CW_IDX  = IDX_W'(CELL_W);

  typedef enum logic [1:0] {
    TRACK  = 2'd0,
    RS_ROW = 2'd1,
    RS_COL = 2'd2
  } state_t;

  state_t state, state_n;

  // Working registers (raw, unmirrored position of the last in-range index)
  logic [IDX_W-1:0] rem, rem_n;
  logic [X_W-1:0]   raw_x, raw_x_n;
  logic [Y_W-1:0]   raw_y, raw_y_n;
  logic [CX_W-1:0]  cnt_col, cnt_col_n, cnt_x, cnt_x_n;
  logic [CY_W-1:0]  cnt_row, cnt_row_n, cnt_y, cnt_y_n;
  logic [IDX_W-1:0] prev_idx, prev_idx_n;
  logic             have_prev, have_prev_n;
  logic             fx, fx_n, fy, fy_n;

  // Next values of the registered outputs
  logic             out_valid_n, oor_n, load_out;
  logic [X_W-1:0]   x_n;
  logic [Y_W-1:0]   y_n;
  logic [CX_W-1:0]  cell_col_n, cell_x_n;
  logic [CY_W-1:0]  cell_row_n, cell_y_n;

  // Request classification
  logic             accept, idx_oor, idx_same, idx_next;
  logic [IDX_W:0]   prev_inc;

  assign accept   = pix_valid && (state == TRACK);
  assign idx_oor  = ({1'b0, pixel_index} >= TOTAL);
  assign prev_inc = {1'b0, prev_idx} + (IDX_W+1)'(1);
  assign idx_same = have_prev && (pixel_index == prev_idx);
  assign idx_next = have_prev &&
                    (({1'b0, pixel_index} == prev_inc) ||
                     ((prev_idx == LAST) && (pixel_index == '0)));

  // One raster step in x: the cell offset carries into the cell column,
  // and an x wrap clears the whole x side and requests a y step.
  logic             x_wrap;
  logic [X_W-1:0]   rx_s;
  logic [CX_W-1:0]  ccol_s, cx_s;
  always_comb begin
    x_wrap = (raw_x == X_MAX);
    rx_s   = raw_x + X_W'(1);
    ccol_s = cnt_col;
    cx_s   = cnt_x + CX_W'(1);
    if (x_wrap) begin
      rx_s   = '0;
      ccol_s = '0;
      cx_s   = '0;
    end else if (cnt_x == CX_LAST) begin
      cx_s   = '0;
      ccol_s = cnt_col + CX_W'(1);
    end
  end

  // One raster step in y, same carry rule; a y wrap clears the y side.
  logic [Y_W-1:0]   ry_s;
  logic [CY_W-1:0]  crow_s, cy_s;
  always_comb begin
    ry_s   = raw_y + Y_W'(1);
    crow_s = cnt_row;
    cy_s   = cnt_y + CY_W'(1);
    if (raw_y == Y_MAX) begin
      ry_s   = '0;
      crow_s = '0;
      cy_s   = '0;
    end else if (cnt_y == CY_LAST) begin
      cy_s   = '0;
      crow_s = cnt_row + CY_W'(1);
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= TRACK;
    else       state <= state_n;
  end

  // FSM: next-state logic
  always_comb begin
    state_n = state;
    case (state)
      TRACK:   if (accept && !idx_oor && !idx_same && !idx_next) state_n = RS_ROW;
      RS_ROW:  if (rem < W_IDX)  state_n = RS_COL;
      RS_COL:  if (rem < CW_IDX) state_n = TRACK;
      default: state_n = TRACK;
    endcase
  end

  // FSM: datapath / output next values
  always_comb begin
    rem_n       = rem;
    raw_x_n     = raw_x;
    raw_y_n     = raw_y;
    cnt_col_n   = cnt_col;
    cnt_x_n     = cnt_x;
    cnt_row_n   = cnt_row;
    cnt_y_n     = cnt_y;
    prev_idx_n  = prev_idx;
    have_prev_n = have_prev;
    fx_n        = fx;
    fy_n        = fy;
    out_valid_n = 1'b0;
    oor_n       = out_of_range;
    load_out    = 1'b0;

    case (state)
      TRACK: begin
        if (accept) begin
          fx_n = flip_x;
          fy_n = flip_y;
          if (idx_oor) begin
            // Coordinates hold; the raster position is no longer trusted.
            out_valid_n = 1'b1;
            oor_n       = 1'b1;
            have_prev_n = 1'b0;
          end else begin
            prev_idx_n = pixel_index;
            if (idx_same) begin
              out_valid_n = 1'b1;
              oor_n       = 1'b0;
              load_out    = 1'b1;
            end else if (idx_next) begin
              raw_x_n   = rx_s;
              cnt_col_n = ccol_s;
              cnt_x_n   = cx_s;
              if (x_wrap) begin
                raw_y_n   = ry_s;
                cnt_row_n = crow_s;
                cnt_y_n   = cy_s;
              end
              out_valid_n = 1'b1;
              oor_n       = 1'b0;
              load_out    = 1'b1;
            end else begin
              rem_n     = pixel_index;
              raw_x_n   = '0;
              raw_y_n   = '0;
              cnt_col_n = '0;
              cnt_x_n   = '0;
              cnt_row_n = '0;
              cnt_y_n   = '0;
            end
          end
        end
      end
      RS_ROW: begin
        if (rem >= W_IDX) begin
          rem_n     = rem - W_IDX;
          raw_y_n   = ry_s;
          cnt_row_n = crow_s;
          cnt_y_n   = cy_s;
        end else begin
          raw_x_n = rem[X_W-1:0];
        end
      end
      RS_COL: begin
        if (rem >= CW_IDX) begin
          rem_n     = rem - CW_IDX;
          cnt_col_n = cnt_col + CX_W'(1);
        end else begin
          // Resync completes here: cell offset lands together with the result.
          cnt_x_n     = rem[CX_W-1:0];
          out_valid_n = 1'b1;
          oor_n       = 1'b0;
          have_prev_n = 1'b1;
          load_out    = 1'b1;
        end
      end
      default: ;
    endcase

    x_n        = x;
    y_n        = y;
    cell_col_n = cell_col;
    cell_row_n = cell_row;
    cell_x_n   = cell_x;
    cell_y_n   = cell_y;
    if (load_out) begin
      x_n        = fx_n ? (X_MAX - raw_x_n) : raw_x_n;
      y_n        = fy_n ? (Y_MAX - raw_y_n) : raw_y_n;
      cell_col_n = cnt_col_n;
      cell_row_n = cnt_row_n;
      cell_x_n   = cnt_x_n;
      cell_y_n   = cnt_y_n;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rem          <= '0;
      raw_x        <= '0;
      raw_y        <= '0;
      cnt_col      <= '0;
      cnt_x        <= '0;
      cnt_row      <= '0;
      cnt_y        <= '0;
      prev_idx     <= '0;
      have_prev    <= 1'b0;
      fx           <= 1'b0;
      fy           <= 1'b0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      out_of_range <= 1'b0;
      x            <= '0;
      y            <= '0;
      cell_col     <= '0;
      cell_row     <= '0;
      cell_x       <= '0;
      cell_y       <= '0;
    end else begin
      rem          <= rem_n;
      raw_x        <= raw_x_n;
      raw_y        <= raw_y_n;
      cnt_col      <= cnt_col_n;
      cnt_x        <= cnt_x_n;
      cnt_row      <= cnt_row_n;
      cnt_y        <= cnt_y_n;
      prev_idx     <= prev_idx_n;
      have_prev    <= have_prev_n;
      fx           <= fx_n;
      fy           <= fy_n;
      busy         <= (state_n != TRACK);
      out_valid    <= out_valid_n;
      out_of_range <= oor_n;
      x            <= x_n;
      y            <= y_n;
      cell_col     <= cell_col_n;
      cell_row     <= cell_row_n;
      cell_x       <= cell_x_n;
      cell_y       <= cell_y_n;
    end
  end

  assign fsm_state = state;

endmodule
